data_to_addr: RTL and testbench
===============================

Name: data_to_addr

Overview:
- Cache-line writeback engine: the write-direction counterpart of the line fetcher on the main system bus.
- Accepts a 64B line plus address from the cache/memory stage and requests the bus arbiter.
- Once granted, issues one address beat tagged WRITE|MEMORY, then streams 8 data beats, each acknowledged by memory.
- Signals ready when the line is committed; used for dirty-line eviction and store writeback.

Parameters:
- BUS_DATA_WIDTH, 64, width of one bus beat and of the address.
- BUS_TAG_WIDTH, 13, width of the bus request tag.
- LINE_BEATS, 8, data beats per cache line (line = BUS_DATA_WIDTH*LINE_BEATS bits).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (reset==0 clears all state immediately).
- enable  in  1  start request; sampled only in IDLE or DONE.
- addr  in  BUS_DATA_WIDTH  byte address of the line; low 6 bits ignored.
- data  in  BUS_DATA_WIDTH*LINE_BEATS  line payload; beat k = data[64k+63:64k].
- abtr_grant  in  1  arbiter grant.
- abtr_reqcyc  out  1  arbiter request.
- bus_busy  out  1  bus owned by this block.
- main_bus_reqcyc  out  1  request beat valid.
- main_bus_req  out  BUS_DATA_WIDTH  address beat, then data beats.
- main_bus_reqtag  out  BUS_TAG_WIDTH  request tag.
- main_bus_reqack  in  1  memory accepted the current beat.
- ready  out  1  writeback complete.

Behaviour:
- States: IDLE, ARB, ADDR, DATA, DONE. Outputs are decoded from the registered state, beat counter and capture registers only (no input-to-output combinational path).
- Reset (reset==0, asynchronous): state=IDLE, beat counter=0, capture registers=0; all outputs 0 immediately, including when reset hits mid-transfer. Any partial line on the bus is abandoned and no ready is produced.
- IDLE: all outputs 0.
  - enable=1 captures addr_q = {addr[63:6], 6'b0} and line_q = data, then -> ARB.
- ARB: abtr_reqcyc=1, everything else 0.
  - abtr_grant=1 -> ADDR; otherwise stay (no timeout).
- ADDR: bus_busy=1, main_bus_reqcyc=1, main_bus_req=addr_q, main_bus_reqtag=13'h0100 (SYSBUS_WRITE<<12 | SYSBUS_MEMORY<<8).
  - Held stable until main_bus_reqack=1, then -> DATA with counter=0.
- DATA: bus_busy=1, main_bus_reqcyc=1, main_bus_req=line_q beat[counter], main_bus_reqtag=13'h0100.
  - reqack=1 with counter<7: counter+1, stay in DATA.
  - reqack=1 with counter==7: -> DONE.
  - reqack=0: the beat is held unchanged.
- DONE: ready=1 (level), bus_busy=0, all bus outputs 0.
  - enable=1 captures new addr/data and -> ARB the same cycle ready drops; otherwise stay.
- Latency with immediate grant and acks: enable at edge 0 -> ARB, ADDR, then 8 DATA cycles -> ready high at cycle 11.
- Other inputs:
  - enable outside IDLE/DONE is ignored; the captured line is immutable until DONE.
  - abtr_grant outside ARB and main_bus_reqack outside ADDR/DATA are ignored.
- main_bus_req and main_bus_reqtag are 0 whenever reqcyc=0.
- Counter is 3 bits and never wraps inside a transaction (exit at 7).

Decomposition:
- Shared package bus_pkg holds:
  - SYSBUS_READ=1, SYSBUS_WRITE=0, SYSBUS_MEMORY=4'b0001;
  - tag helper constants TAG_MEM_READ=13'h1100 and TAG_MEM_WRITE=13'h0100;
  - LINE_BYTES=64;
  - the state enum typedef.
- The read-side fetcher reuses the same package.
- No sub-module: the beat mux over line_q is inline; the block is a single FSM.

Test Plan:
- Basic writeback: addr=0x1000_0047, data beats k=0xA0+k, grant and ack immediate.
  - Required: address beat 0x1000_0040 with tag 0x0100, then beats 0xA0..0xA7 in order, ready=1 at cycle 11 and held.
- Ack stalls: reqack low 3 cycles on the address beat and 2 cycles on beat 4.
  - Required: req/tag/reqcyc stable during stalls, no beat skipped or duplicated, bus_busy=1 throughout.
- Grant delay: grant withheld 5 cycles.
  - Required: abtr_reqcyc=1 and bus_busy=0 for those cycles, no reqcyc.
- Input change mid-transfer: change data/addr and pulse enable during DATA.
  - Required: original line still sent, enable ignored.
- Back-to-back: enable=1 in DONE with a new line.
  - Required: ready drops next cycle, ARB re-entered, second line sent correctly.
- Async reset at beat 3 (reset=0 between edges).
  - Required: all outputs 0 before the next edge; after release, IDLE and ready=0 until a new enable.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared system-bus definitions for the line fetcher (read side) and the
// line writeback engine (write side).
//   - Request direction / target codes and the composed 13-bit request tags.
//   - Cache line size in bytes.
//   - State encoding of the writeback FSM.
package bus_pkg;

    localparam logic       SYSBUS_READ   = 1'b1;
    localparam logic       SYSBUS_WRITE  = 1'b0;
    localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;

    // Tag layout: {direction[12], target[11:8], 8'h00}
    localparam logic [12:0] TAG_MEM_READ  = {SYSBUS_READ,  SYSBUS_MEMORY, 8'h00};
    localparam logic [12:0] TAG_MEM_WRITE = {SYSBUS_WRITE, SYSBUS_MEMORY, 8'h00};

    localparam int unsigned LINE_BYTES = 64;

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StAddr,
        StData,
        StDone
    } wb_state_e;

endpackage

// File: rtl/data_to_addr.sv
// Cache-line writeback engine on the main system bus.
// Captures a line and its address, requests the bus arbiter, then drives one
// address beat tagged WRITE|MEMORY followed by LINE_BEATS data beats, each
// advanced only on main_bus_reqack_i. ready_o is held high once the line is
// committed, until the next enable_i.
//
// Ports:
//   clk_i              system clock, rising edge
//   rst_ni             asynchronous active-low reset
//   enable_i           start request, sampled in idle/done only
//   addr_i             line byte address (offset bits dropped)
//   data_i             line payload, beat k = data_i[64k +: 64]
//   abtr_grant_i       arbiter grant
//   abtr_reqcyc_o      arbiter request
//   bus_busy_o         bus owned by this block
//   main_bus_reqcyc_o  request beat valid
//   main_bus_req_o     address beat, then data beats
//   main_bus_reqtag_o  request tag
//   main_bus_reqack_i  memory accepted current beat
//   ready_o            writeback complete (level)
module data_to_addr
    import bus_pkg::*;
#(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned LINE_BEATS     = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 enable_i,
    input  logic [BUS_DATA_WIDTH-1:0]            addr_i,
    input  logic [BUS_DATA_WIDTH*LINE_BEATS-1:0] data_i,
    input  logic                                 abtr_grant_i,
    output logic                                 abtr_reqcyc_o,
    output logic                                 bus_busy_o,
    output logic                                 main_bus_reqcyc_o,
    output logic [BUS_DATA_WIDTH-1:0]            main_bus_req_o,
    output logic [BUS_TAG_WIDTH-1:0]             main_bus_reqtag_o,
    input  logic                                 main_bus_reqack_i,
    output logic                                 ready_o
);

    localparam int unsigned CntW = $clog2(LINE_BEATS);
    localparam int unsigned OffW = $clog2(LINE_BYTES);
    localparam logic [CntW-1:0] LastBeat = CntW'(LINE_BEATS - 1);

    wb_state_e                            state_q, state_d;
    logic [CntW-1:0]                      cnt_q, cnt_d;
    logic [BUS_DATA_WIDTH-1:0]            addr_q, addr_d;
    logic [BUS_DATA_WIDTH*LINE_BEATS-1:0] line_q, line_d;
    logic [BUS_DATA_WIDTH-1:0]            beat;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
        end
    end

    // Next-state: the captured line only changes on a new start from idle/done.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        line_d  = line_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (enable_i) begin
                    addr_d  = {addr_i[BUS_DATA_WIDTH-1:OffW], OffW'(0)};
                    line_d  = data_i;
                    state_d = StArb;
                end
            end
            StArb: begin
                if (abtr_grant_i) begin
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (main_bus_reqack_i) begin
                    cnt_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (main_bus_reqack_i) begin
                    if (cnt_q == LastBeat) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Beat select over the captured line.
    always_comb begin
        beat = '0;
        for (int k = 0; k < LINE_BEATS; k++) begin
            if (cnt_q == CntW'(k)) begin
                beat = line_q[k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
            end
        end
    end

    // Outputs decode registered state only; req/tag stay 0 whenever reqcyc is 0.
    always_comb begin
        abtr_reqcyc_o     = 1'b0;
        bus_busy_o        = 1'b0;
        main_bus_reqcyc_o = 1'b0;
        main_bus_req_o    = '0;
        main_bus_reqtag_o = '0;
        ready_o           = 1'b0;
        unique case (state_q)
            StArb: abtr_reqcyc_o = 1'b1;
            StAddr: begin
                bus_busy_o        = 1'b1;
                main_bus_reqcyc_o = 1'b1;
                main_bus_req_o    = addr_q;
                main_bus_reqtag_o = BUS_TAG_WIDTH'(TAG_MEM_WRITE);
            end
            StData: begin
                bus_busy_o        = 1'b1;
                main_bus_reqcyc_o = 1'b1;
                main_bus_req_o    = beat;
                main_bus_reqtag_o = BUS_TAG_WIDTH'(TAG_MEM_WRITE);
            end
            StDone: ready_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_data_to_addr.sv
module tb_data_to_addr;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         enable = 1'b0;
    logic [63:0]  addr = '0;
    logic [511:0] data = '0;
    logic         grant = 1'b0;
    logic         ack = 1'b0;
    logic         abtr_reqcyc;
    logic         bus_busy;
    logic         reqcyc;
    logic [63:0]  req;
    logic [12:0]  reqtag;
    logic         ready;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_to_addr dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .enable_i          (enable),
        .addr_i            (addr),
        .data_i            (data),
        .abtr_grant_i      (grant),
        .abtr_reqcyc_o     (abtr_reqcyc),
        .bus_busy_o        (bus_busy),
        .main_bus_reqcyc_o (reqcyc),
        .main_bus_req_o    (req),
        .main_bus_reqtag_o (reqtag),
        .main_bus_reqack_i (ack),
        .ready_o           (ready)
    );

    function automatic logic [511:0] mk_line(input logic [63:0] base);
        logic [511:0] l;
        for (int k = 0; k < 8; k++) l[k*64 +: 64] = base + 64'(k);
        return l;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full output vector check: {abtr, busy, reqcyc, ready}, req, tag.
    task automatic chk_out(input string tag, input logic [3:0] ctl, input logic [63:0] exp_req);
        chk({tag, ".ctl"}, 64'({abtr_reqcyc, bus_busy, reqcyc, ready}), 64'(ctl));
        chk({tag, ".req"}, req, exp_req);
        chk({tag, ".tag"}, 64'(reqtag), ctl[1] ? 64'h0100 : 64'h0);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    localparam logic [3:0] C_IDLE = 4'b0000;
    localparam logic [3:0] C_ARB  = 4'b1000;
    localparam logic [3:0] C_BUS  = 4'b0110;
    localparam logic [3:0] C_DONE = 4'b0001;

    initial begin
        #1 rst_n = 1'b0;
        tick();
        chk_out("reset", C_IDLE, 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_out("idle", C_IDLE, 64'h0);

        // Basic writeback, immediate grant and acks.
        enable = 1'b1;
        addr   = 64'h1000_0047;
        data   = mk_line(64'hA0);
        grant  = 1'b1;
        ack    = 1'b1;
        tick();
        enable = 1'b0;
        chk_out("t1.arb", C_ARB, 64'h0);
        tick();
        chk_out("t1.addr", C_BUS, 64'h1000_0040);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_out($sformatf("t1.beat%0d", k), C_BUS, 64'hA0 + 64'(k));
        end
        tick();
        chk_out("t1.done", C_DONE, 64'h0);
        tick();
        chk_out("t1.held", C_DONE, 64'h0);

        // Back-to-back from done, grant withheld 5 cycles, ack stalls.
        enable = 1'b1;
        addr   = 64'h2000_00FF;
        data   = mk_line(64'hB0);
        grant  = 1'b0;
        ack    = 1'b0;
        tick();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_out($sformatf("t2.arbwait%0d", i), C_ARB, 64'h0);
            if (i < 4) tick();
        end
        grant = 1'b1;
        tick();
        grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_out($sformatf("t2.addrstall%0d", i), C_BUS, 64'h2000_00C0);
            if (i < 2) tick();
        end
        ack = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            chk_out($sformatf("t2.beat%0d", k), C_BUS, 64'hB0 + 64'(k));
            if (k == 2) begin
                // Inputs change and enable pulses mid-transfer.
                enable = 1'b1;
                addr   = 64'hDEAD_0000;
                data   = mk_line(64'hC0);
            end else begin
                enable = 1'b0;
            end
            if (k == 4) begin
                ack = 1'b0;
                tick();
                chk_out("t2.stall4a", C_BUS, 64'hB4);
                tick();
                chk_out("t2.stall4b", C_BUS, 64'hB4);
                ack = 1'b1;
            end
            tick();
        end
        chk_out("t2.done", C_DONE, 64'h0);

        // Async reset in the middle of beat 3.
        enable = 1'b1;
        addr   = 64'h3000_0000;
        data   = mk_line(64'hD0);
        grant  = 1'b1;
        ack    = 1'b1;
        tick();
        enable = 1'b0;
        repeat (5) tick();
        chk_out("t3.beat3", C_BUS, 64'hD3);
        #2 rst_n = 1'b0;
        #1 chk_out("t3.inreset", C_IDLE, 64'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("t3.idle%0d", i), C_IDLE, 64'h0);
        end

        // New enable after reset starts cleanly.
        enable = 1'b1;
        addr   = 64'h4000_0010;
        data   = mk_line(64'hE0);
        tick();
        enable = 1'b0;
        chk_out("t4.arb", C_ARB, 64'h0);
        tick();
        chk_out("t4.addr", C_BUS, 64'h4000_0000);
        tick();
        chk_out("t4.beat0", C_BUS, 64'hE0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
